// File: rtl/uart_pkg.sv
// uart_pkg: shared FSM states and timing helpers for the buffered UART transmitter
package uart_pkg;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  localparam int BIT_CNT_W = 4;
  function automatic int calc_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction
endpackage

// File: rtl/uart_fifo.sv
// uart_fifo: synchronous FIFO; pushes while full and pops while empty are ignored
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic do_push, do_pop;
  assign do_push = push && !full;
  assign do_pop = pop && !empty;
  assign full = level == (AW+1)'(DEPTH);
  assign empty = level == '0;
  assign rdata = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      level <= level + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= wdata;
endmodule

// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: FIFO-fronted UART transmitter; define UART_TX_PARITY_EN to add a parity bit
module uart_tx_buffered import uart_pkg::*; #(
  parameter int CLK_HZ     = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int DEPTH      = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   send,
  input  logic [DATA_BITS-1:0]   data,
  output logic                   ready,
  output logic                   tx,
  output logic                   busy,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow
);
  localparam int DIV = calc_div(CLK_HZ, BAUD);
  localparam int CW = $clog2(DIV);
  tx_state_t state;
  logic [CW-1:0] cnt;
  logic [BIT_CNT_W-1:0] idx;
  logic [DATA_BITS-1:0] shreg, fifo_out;
  logic full, empty, tick, frame_end, pop;
  assign tick = cnt == '0;
  assign frame_end = state == STOP && tick && idx == BIT_CNT_W'(STOP_BITS - 1);
  // back-to-back frames: the pop at the end of STOP skips IDLE entirely
  assign pop = !empty && (state == IDLE || frame_end);
  assign ready = !full;
  assign busy = state != IDLE || level != '0;
  uart_fifo #(.WIDTH(DATA_BITS), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .push(send),
    .pop(pop),
    .wdata(data),
    .rdata(fifo_out),
    .full(full),
    .empty(empty),
    .level(level)
  );
`ifdef UART_TX_PARITY_EN
  logic par;
`else
  logic unused_parity;
  assign unused_parity = PARITY_ODD != 0;
`endif
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      tx <= 1'b1;
      cnt <= '0;
      idx <= '0;
      shreg <= '0;
      overflow <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par <= 1'b0;
`endif
    end else begin
      overflow <= send && full;
      cnt <= (state == IDLE || tick) ? CW'(DIV - 1) : cnt - 1'b1;
      if (pop) begin
        state <= START;
        tx <= 1'b0;
        shreg <= fifo_out;
`ifdef UART_TX_PARITY_EN
        par <= ^fifo_out ^ (PARITY_ODD != 0);
`endif
      end else if (tick && state != IDLE) begin
        case (state)
          START: begin
            state <= DATA;
            tx <= shreg[0];
            shreg <= shreg >> 1;
            idx <= '0;
          end
          DATA: begin
            if (idx == BIT_CNT_W'(DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx <= par;
`else
              state <= STOP;
              tx <= 1'b1;
              idx <= '0;
`endif
            end else begin
              tx <= shreg[0];
              shreg <= shreg >> 1;
              idx <= idx + 1'b1;
            end
          end
          PARITY: begin
            state <= STOP;
            tx <= 1'b1;
            idx <= '0;
          end
          STOP: begin
            if (frame_end) state <= IDLE;
            else idx <= idx + 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
